// File: rtl/readout_pkg.sv
// Shared types and limits for the sensor readout path: FSM state encoding,
// exposure-count width and the accepted exposure window.
package readout_pkg;

    localparam int EXP_W = 5;
    localparam logic [EXP_W-1:0] EXP_MIN = 5'd2;
    localparam logic [EXP_W-1:0] EXP_MAX = 5'd30;
    localparam logic [EXP_W-1:0] EXP_SAT = 5'd31;

    typedef enum logic [2:0] {
        IDLE,
        ERASED,
        EXPOSING,
        CONVERTED,
        READ_R1,
        READ_R2,
        STREAM
    } state_e;

endpackage

// File: rtl/pixel_stream_out.sv
// Streams the 2*COLS-pixel frame buffer out over valid/ready, row-major,
// flagging the final pixel with last_o.
module pixel_stream_out #(
    parameter int DATA_W = 8,
    parameter int COLS   = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_i,
    input  logic [2*COLS-1:0][DATA_W-1:0]    pix_i,
    input  logic                             ready_i,
    output logic [DATA_W-1:0]                data_o,
    output logic                             valid_o,
    output logic                             last_o,
    output logic                             done_o
);
    localparam int NPIX  = 2 * COLS;
    localparam int IDX_W = $clog2(NPIX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    logic             valid_q;
    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else if (start_i) begin
            valid_q <= 1'b1;
            idx_q   <= '0;
        end else if (valid_q && ready_i) begin
            if (idx_q == LAST_IDX) begin
                valid_q <= 1'b0;
                idx_q   <= '0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    // The buffer is not written while streaming, so the mux output holds under backpressure.
    assign data_o  = valid_q ? pix_i[idx_q] : '0;
    assign valid_o = valid_q;
    assign last_o  = valid_q && (idx_q == LAST_IDX);
    assign done_o  = last_o && ready_i;

endmodule

// File: rtl/readout_capture.sv
// Two-row sensor readout capture: sequences erase/expose/adc, captures both rows
// on the nre strobes and streams the frame. READOUT_CAPTURE_EXPOSURE_CHECK_EN
// enables rejecting frames whose exposure count lies outside 2..30.
//
// state     | meaning
// IDLE      | waiting for erase
// ERASED    | pixels erased, waiting for expose
// EXPOSING  | counting expose cycles until adc
// CONVERTED | conversion done, waiting for nre1
// READ_R1   | capturing row 1 while nre1 low
// READ_R2   | capturing row 2 while nre2 low
// STREAM    | frame buffer being streamed out
module readout_capture
    import readout_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COLS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              erase,
    input  logic              expose,
    input  logic              adc,
    input  logic              nre1,
    input  logic              nre2,
    input  logic [DATA_W-1:0] data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic [EXP_W-1:0]  exposure_cnt,
    output logic              frame_done,
    output logic              protocol_err
);
    localparam int CNT_W  = $clog2(COLS + 1);
    localparam int SLOT_W = $clog2(2 * COLS);
    localparam logic [CNT_W-1:0] COLS_C = CNT_W'(COLS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    col_q, col_d;
    logic                ovf_q, ovf_d;
    logic                hold_q, hold_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [EXP_W-1:0]    exp_cnt_q, exp_cnt_d;
    logic                err_q, err_d;
    logic                done_q;
    logic                nre1_q, nre2_q;
    logic [2*COLS-1:0][DATA_W-1:0] buf_q;

    logic                cap_en, cap_row;
    logic [CNT_W-1:0]    cap_col;
    logic [SLOT_W-1:0]   cap_slot;
    logic                stream_start, stream_done;
    logic                fall1, fall2;

    assign fall1 = nre1_q && !nre1;
    assign fall2 = nre2_q && !nre2;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        ovf_d        = ovf_q;
        hold_d       = hold_q;
        exp_d        = exp_q;
        exp_cnt_d    = exp_cnt_q;
        err_d        = 1'b0;
        cap_en       = 1'b0;
        cap_row      = 1'b0;
        cap_col      = col_q;
        stream_start = 1'b0;

        if (erase && state_q != STREAM) begin
            state_d = ERASED;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall1 || fall2) err_d = 1'b1;
                end
                ERASED: begin
                    if (fall1 || fall2) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (expose) begin
                        state_d = EXPOSING;
                        exp_d   = EXP_W'(1);
                    end
                end
                EXPOSING: begin
                    if (fall1 || fall2) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (adc) begin
                        state_d   = CONVERTED;
                        exp_cnt_d = exp_q;
`ifdef READOUT_CAPTURE_EXPOSURE_CHECK_EN
                        if (exp_q < EXP_MIN || exp_q > EXP_MAX) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
`endif
                    end else if (expose && exp_q != EXP_SAT) begin
                        exp_d = exp_q + EXP_W'(1);
                    end
                end
                CONVERTED: begin
                    if (!nre2) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (!nre1) begin
                        state_d = READ_R1;
                        cap_en  = 1'b1;
                        cap_col = '0;
                        col_d   = CNT_W'(1);
                        ovf_d   = 1'b0;
                    end
                end
                READ_R1: begin
                    if (!nre1 && !nre2) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (!nre1) begin
                        // A fresh falling edge after a complete row is a second row-1 pulse.
                        if (fall1 && col_q == COLS_C) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else if (col_q < COLS_C) begin
                            cap_en = 1'b1;
                            col_d  = col_q + CNT_W'(1);
                        end else if (!ovf_q) begin
                            err_d = 1'b1;
                            ovf_d = 1'b1;
                        end
                    end else if (col_q != COLS_C) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (!nre2) begin
                        cap_en       = 1'b1;
                        cap_row      = 1'b1;
                        cap_col      = '0;
                        col_d        = CNT_W'(1);
                        state_d      = (COLS == 1) ? STREAM : READ_R2;
                        stream_start = (COLS == 1);
                        hold_d       = 1'b1;
                    end
                end
                READ_R2: begin
                    if (!nre1 || nre2) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cap_en  = 1'b1;
                        cap_row = 1'b1;
                        col_d   = col_q + CNT_W'(1);
                        if (col_q == COLS_C - CNT_W'(1)) begin
                            state_d      = STREAM;
                            stream_start = 1'b1;
                            hold_d       = 1'b1;
                        end
                    end
                end
                STREAM: begin
                    // hold_q covers nre2 still low from the last row-2 capture: one overrun error.
                    hold_d = 1'b0;
                    err_d  = (hold_q && !nre2) || fall1 || fall2;
                    if (stream_done) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cap_slot = cap_row ? (SLOT_W'(COLS) + SLOT_W'(cap_col)) : SLOT_W'(cap_col);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            ovf_q     <= 1'b0;
            hold_q    <= 1'b0;
            exp_q     <= '0;
            exp_cnt_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            nre1_q    <= 1'b1;
            nre2_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            ovf_q     <= ovf_d;
            hold_q    <= hold_d;
            exp_q     <= exp_d;
            exp_cnt_q <= exp_cnt_d;
            err_q     <= err_d;
            done_q    <= stream_done;
            nre1_q    <= nre1;
            nre2_q    <= nre2;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) buf_q[cap_slot] <= data;
    end

    pixel_stream_out #(
        .DATA_W (DATA_W),
        .COLS   (COLS)
    ) u_stream (
        .clk     (clk),
        .reset   (reset),
        .start_i (stream_start),
        .pix_i   (buf_q),
        .ready_i (out_ready),
        .data_o  (out_data),
        .valid_o (out_valid),
        .last_o  (out_last),
        .done_o  (stream_done)
    );

    assign exposure_cnt = exp_cnt_q;
    assign frame_done   = done_q;
    assign protocol_err = err_q;

endmodule
